// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin front end for one shared 8-bit adder.
// Operands are latched on accept; the held response is rsp_sum/rsp_carry of those operands.
// Optional statistics counters are enabled by defining ADDER_ARB_STATS_EN.
module adder_arbiter #(
  parameter int unsigned CNT_W   = 16,
  parameter logic        RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_sum,
  output logic       rsp_carry
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_RESP = 1'b1;

  // Counter width must be at least one bit.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("adder_arbiter: CNT_W must be >= 1");
  end

  logic [0:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;

  logic              can_accept_c;
  logic              grant_vld_c;
  logic              grant_id_c;
  logic              accept_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;
  logic [DATA_W:0]   sum_c;

  // Round-robin grant: a tie goes to the requester that did not win last time.
  always_comb begin
    grant_vld_c  = req0_valid | req1_valid;
    grant_id_c   = 1'b0;
    if (req0_valid & req1_valid) begin
      grant_id_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id_c = 1'b1;
    end
    can_accept_c = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);
    accept_c     = can_accept_c & grant_vld_c & rst_n;
    sel_a_c      = grant_id_c ? req1_a : req0_a;
    sel_b_c      = grant_id_c ? req1_b : req0_b;
  end

  assign req0_ready = accept_c & ~grant_id_c;
  assign req1_ready = accept_c &  grant_id_c;

  // Next-state: accept latches operands; an unreplaced consumed response returns to IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!accept_c && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept_c) begin
      last_grant_d = grant_id_c;
      rsp_id_d     = grant_id_c;
      op_a_d       = sel_a_c;
      op_b_d       = sel_b_c;
    end
  end

  // State and held-operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ~RR_INIT;
      rsp_id_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  // Shared adder fed only from the held operands, so the result is stable while held.
  assign sum_c     = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign rsp_sum   = sum_c[DATA_W-1:0];
  assign rsp_carry = sum_c[DATA_W];
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic             acc_carry_c;

  // Saturating event counters for accepted requests.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    carry_cnt_d  = carry_cnt_q;
    acc_carry_c  = ((DATA_W+1)'(sel_a_c) + (DATA_W+1)'(sel_b_c)) > (DATA_W+1)'(255);
    if (accept_c) begin
      if (!grant_id_c && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
      if (grant_id_c && (grant_cnt1_q != '1))  grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
      if (acc_carry_c && (carry_cnt_q != '1))  carry_cnt_d  = carry_cnt_q + CNT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      carry_cnt_q  <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      carry_cnt_q  <= carry_cnt_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign carry_cnt  = carry_cnt_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: directed vector table, corner sequences, random vs. reference model.
module tb_adder_arbiter;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry;
  logic [7:0] rsp_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1, carry_cnt;
`endif

  adder_arbiter #(.CNT_W(TB_CNT_W), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
`ifdef ADDER_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .carry_cnt(carry_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: transaction-level view of the held response and arbitration history.
  int m_valid, m_id, m_a, m_b, m_last;
  int m_cnt0, m_cnt1, m_ccnt;

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_a = 0; m_b = 0; m_last = 1;
    m_cnt0 = 0; m_cnt1 = 0; m_ccnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    check("reset_rsp_sum", 32'(rsp_sum), 0);
    check("reset_rsp_carry", 32'(rsp_carry), 0);
    check("reset_req0_ready", 32'(req0_ready), 0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // One cycle: drive, check against model mid-cycle, advance model across the edge.
  task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                      input logic rr);
    int g, can, s;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    @(negedge clk);
    can = (m_valid == 0 || rr) ? 1 : 0;
    if (v0 && v1) g = 1 - m_last;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    if (!can) g = -1;
    s = m_a + m_b;
    check("req0_ready", 32'(req0_ready), 32'(g == 0));
    check("req1_ready", 32'(req1_ready), 32'(g == 1));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("rsp_sum", 32'(rsp_sum), 32'(s % 256));
    check("rsp_carry", 32'(rsp_carry), 32'(s > 255));
`ifdef ADDER_ARB_STATS_EN
    check("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
    check("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
    check("carry_cnt", 32'(carry_cnt), 32'(m_ccnt));
`endif
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1; m_id = g; m_last = g;
      m_a = (g == 0) ? int'(a0) : int'(a1);
      m_b = (g == 0) ? int'(b0) : int'(b1);
      if (g == 0 && m_cnt0 < CNT_MAX) m_cnt0++;
      if (g == 1 && m_cnt1 < CNT_MAX) m_cnt1++;
      if (m_a + m_b > 255 && m_ccnt < CNT_MAX) m_ccnt++;
    end else if (m_valid != 0 && rr) begin
      m_valid = 0;
    end
    #1;
  endtask

  typedef struct packed {
    logic v0; logic [7:0] a0; logic [7:0] b0;
    logic v1; logic [7:0] a1; logic [7:0] b1;
    logic rr;
    logic r0; logic r1;
    logic valid; logic id; logic [7:0] sum; logic carry;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // inputs: v0 a0 b0 v1 a1 b1 rr | readys r0 r1 | after edge: valid id sum carry
    tbl[0]  = '{1'b1, 8'd10,  8'd10,  1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd20,  1'b0};
    tbl[1]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'hFF,  8'hFF,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFE,  1'b1};
    tbl[2]  = '{1'b1, 8'd1,   8'd2,   1'b1, 8'd3,   8'd4,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3,   1'b0};
    tbl[3]  = '{1'b1, 8'd5,   8'd6,   1'b1, 8'd7,   8'd8,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd15,  1'b0};
    tbl[4]  = '{1'b1, 8'd200, 8'd100, 1'b1, 8'd1,   8'd1,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd44,  1'b1};
    tbl[5]  = '{1'b0, 8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd44,  1'b1};
    tbl[6]  = '{1'b1, 8'd128, 8'd128, 1'b0, 8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1};
    tbl[7]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd9,   8'd9,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1};
    tbl[8]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd9,   8'd9,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd18,  1'b0};
    tbl[9]  = '{1'b0, 8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd18,  1'b0};
    tbl[10] = '{1'b0, 8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd18,  1'b0};

    @(posedge clk); #1;
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      req0_valid = tbl[i].v0; req0_a = tbl[i].a0; req0_b = tbl[i].b0;
      req1_valid = tbl[i].v1; req1_a = tbl[i].a1; req1_b = tbl[i].b1;
      rsp_ready  = tbl[i].rr;
      @(negedge clk);
      check($sformatf("tbl%0d_req0_ready", i), 32'(req0_ready), 32'(tbl[i].r0));
      check($sformatf("tbl%0d_req1_ready", i), 32'(req1_ready), 32'(tbl[i].r1));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].id));
      check($sformatf("tbl%0d_rsp_sum", i), 32'(rsp_sum), 32'(tbl[i].sum));
      check($sformatf("tbl%0d_rsp_carry", i), 32'(rsp_carry), 32'(tbl[i].carry));
    end

    // Fairness from reset: both valid, consumer always ready -> ids 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'(k), 8'd1, 1'b1, 8'(k + 20), 8'd2, 1'b1);
      check("fair_valid", 32'(rsp_valid), 1);
      check("fair_id", 32'(rsp_id), 32'(k % 2));
    end

    // Consumer stall: response held constant, no new grant, then drains.
    do_reset();
    step(1'b1, 8'd50, 8'd60, 1'b0, 8'd0, 8'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
      check("stall_sum", 32'(rsp_sum), 110);
      check("stall_req0_ready", 32'(req0_ready), 0);
    end
    step(1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0, 1'b1);
    check("drain_sum", 32'(rsp_sum), 2);
    step(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("drain_valid", 32'(rsp_valid), 0);

    // Asynchronous reset while holding a response.
    step(1'b0, 8'd0, 8'd0, 1'b1, 8'd7, 8'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 0);
    check("async_rst_sum", 32'(rsp_sum), 0);
    do_reset();
    step(1'b1, 8'd3, 8'd3, 1'b1, 8'd4, 8'd4, 1'b1);
    check("post_rst_tie_id", 32'(rsp_id), 0);

`ifdef ADDER_ARB_STATS_EN
    // Saturating counters: five req0 accepts, three with carry.
    do_reset();
    step(1'b1, 8'd200, 8'd100, 1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 8'd255, 8'd1,   1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 8'd1,   8'd1,   1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 8'd128, 8'd128, 1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 8'd2,   8'd2,   1'b0, 8'd0, 8'd0, 1'b1);
    check("stats_grant_cnt0", 32'(grant_cnt0), 3);
    check("stats_grant_cnt1", 32'(grant_cnt1), 0);
    check("stats_carry_cnt", 32'(carry_cnt), 3);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
